// File: rtl/ifft_8_serial.sv
// ifft_8_serial: serial 8-point radix-2 IFFT with one shared butterfly; define IFFT_ROUND_EN for round-half-up instead of floor
module ifft_8_serial #(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_real,
  input  logic [W-1:0] in_image,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_real,
  output logic [W-1:0] out_image,
  output logic         out_last,
  output logic         busy
);
  localparam int P = 1 << N;
  localparam logic [1:0] LOAD = 2'd0, COMP = 2'd1, UNLOAD = 2'd2;
`ifdef IFFT_ROUND_EN
  localparam logic signed [W+8:0] R7 = (W+9)'(64);
`else
  localparam logic signed [W+8:0] R7 = '0;
`endif
  logic [1:0] state;
  logic [3:0] cnt;
  logic signed [W-1:0] mem_re [P];
  logic signed [W-1:0] mem_im [P];
  logic [1:0] st, bf, k;
  logic [2:0] ai, aj;
  logic signed [W-1:0] ar, aim, br, bi, nbi;
  logic signed [W+8:0] prr, pii, pd, ps, pn;
  logic signed [W:0] tr, ti;

  function automatic logic signed [W:0] shr7(input logic signed [W+8:0] x);
    logic signed [W+8:0] y;
    y = (x + R7) >>> 7;
    return y[W:0];
  endfunction

  function automatic logic signed [W-1:0] halve(input logic signed [W:0] x);
`ifdef IFFT_ROUND_EN
    logic signed [W+1:0] z;
    z = ((W+2)'(x) + (W+2)'(1)) >>> 1;
    return z[W+1:W-1] == 3'b001 ? {1'b0, {(W-1){1'b1}}} : z[W-1:0];
`else
    logic signed [W:0] z;
    z = x >>> 1;
    return z[W-1:0];
`endif
  endfunction

  always_comb begin
    st = cnt[3:2];
    bf = cnt[1:0];
    ai = st == 2'd0 ? {bf, 1'b0} : st == 2'd1 ? {bf[1], 1'b0, bf[0]} : {1'b0, bf};
    aj = ai | (3'd1 << st);
    k = st == 2'd0 ? 2'd0 : st == 2'd1 ? {bf[0], 1'b0} : bf;
    ar = mem_re[ai];
    aim = mem_im[ai];
    br = mem_re[aj];
    bi = mem_im[aj];
    nbi = bi == {1'b1, {(W-1){1'b0}}} ? {1'b0, {(W-1){1'b1}}} : -bi;
    prr = (W+9)'(br) * (W+9)'(91);
    pii = (W+9)'(bi) * (W+9)'(91);
    pd = prr - pii;
    ps = prr + pii;
    pn = -ps;
    tr = k == 2'd0 ? (W+1)'(br) : k == 2'd2 ? (W+1)'(nbi) : k == 2'd1 ? shr7(pd) : shr7(pn);
    ti = k == 2'd0 ? (W+1)'(bi) : k == 2'd2 ? (W+1)'(br) : k == 2'd1 ? shr7(ps) : shr7(pd);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      cnt <= '0;
    end else if (state == LOAD) begin
      if (in_valid) begin
        mem_re[{cnt[0], cnt[1], cnt[2]}] <= in_real;
        mem_im[{cnt[0], cnt[1], cnt[2]}] <= in_image;
        cnt <= cnt == 4'(P - 1) ? '0 : cnt + 4'd1;
        state <= cnt == 4'(P - 1) ? COMP : LOAD;
      end
    end else if (state == COMP) begin
      mem_re[ai] <= halve((W+1)'(ar) + tr);
      mem_im[ai] <= halve((W+1)'(aim) + ti);
      mem_re[aj] <= halve((W+1)'(ar) - tr);
      mem_im[aj] <= halve((W+1)'(aim) - ti);
      cnt <= cnt == 4'(N * P / 2 - 1) ? '0 : cnt + 4'd1;
      state <= cnt == 4'(N * P / 2 - 1) ? UNLOAD : COMP;
    end else if (state == UNLOAD) begin
      if (out_ready) begin
        cnt <= cnt == 4'(P - 1) ? '0 : cnt + 4'd1;
        state <= cnt == 4'(P - 1) ? LOAD : UNLOAD;
      end
    end else begin
      state <= LOAD;
    end
  end

  assign in_ready = state == LOAD;
  assign busy = state == COMP || state == UNLOAD;
  assign out_valid = state == UNLOAD;
  assign out_real = out_valid ? mem_re[cnt[2:0]] : '0;
  assign out_image = out_valid ? mem_im[cnt[2:0]] : '0;
  assign out_last = out_valid && cnt == 4'(P - 1);
endmodule

// File: tb/tb_ifft_8_serial.sv
// tb_ifft_8_serial: table-driven scoreboard bench for ifft_8_serial against exact vectors and a real-valued IFFT
module tb_ifft_8_serial;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [7:0] in_real = 0, in_image = 0;
  logic in_ready, out_valid, out_last, busy;
  logic [7:0] out_real, out_image;

  ifft_8_serial dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_image(in_image), .out_valid(out_valid),
    .out_ready(out_ready), .out_real(out_real), .out_image(out_image),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int xr[8];
    int xi[8];
    real er[8];
    real ei[8];
    real tol;
  } vec_t;
  typedef struct {
    real re;
    real im;
    bit last;
    real tol;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;
  bit bp = 0;
  int b2r[8] = '{8, 0, -8, 0, 8, 0, -8, 0};
  int b2i[8] = '{0, 8, 0, -8, 0, 8, 0, -8};

  task automatic check(input string nm, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic checkr(input string nm, input int got, input real want, input real tol);
    real d;
    d = got - want;
    if (d < 0) d = -d;
    n_cmp++;
    if (d > tol + 0.001) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0.3f (tol %0.1f)", nm, got, want, tol);
    end
  endtask

  task automatic send(input int v, input bit push, input bit hold);
    int w;
    if (push)
      for (int m = 0; m < 8; m++)
        sb.push_back('{vecs[v].er[m], vecs[v].ei[m], m == 7, vecs[v].tol});
    for (int n = 0; n < 8; n++) begin
      in_valid = 1;
      in_real = 8'(vecs[v].xr[n]);
      in_image = 8'(vecs[v].xi[n]);
      w = 0;
      while (!in_ready && w < 400) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        n_cmp++;
        n_bad++;
        $display("FAIL in_ready_timeout: got 0 expected 1");
      end
      @(posedge clk);
      #1;
    end
    if (hold) in_real = 8'h55;
    else in_valid = 0;
  endtask

  task automatic wait_empty();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("drain_queue_size", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_last();
    int w;
    bit done;
    w = 0;
    done = 0;
    while (!done && w < 400) begin
      @(negedge clk);
      w++;
      if (bp) check("in_ready_while_busy", int'(in_ready), 0);
      done = out_valid && out_ready && out_last;
    end
    check("last_handshake_seen", int'(done), 1);
  endtask

  initial begin
    int lat;
    for (int v = 0; v < 6; v++) begin
      vecs[v].tol = v < 3 ? 0.0 : 2.0;
      for (int m = 0; m < 8; m++) begin
        vecs[v].xr[m] = v == 1 ? 64 : (v == 0 && m == 0) || (v == 2 && m == 2) ? 64 : 0;
        vecs[v].xi[m] = 0;
        vecs[v].er[m] = v == 0 ? 8.0 : v == 1 ? (m == 0 ? 64.0 : 0.0) : b2r[m];
        vecs[v].ei[m] = v == 2 ? b2i[m] : 0.0;
      end
      if (v >= 3) begin
        for (int m = 0; m < 8; m++) begin
          vecs[v].xr[m] = int'($urandom_range(0, 80)) - 40;
          vecs[v].xi[m] = int'($urandom_range(0, 80)) - 40;
        end
        for (int m = 0; m < 8; m++) begin
          real sr, si, a;
          sr = 0.0;
          si = 0.0;
          for (int q = 0; q < 8; q++) begin
            a = 2.0 * 3.14159265358979 * q * m / 8.0;
            sr = sr + vecs[v].xr[q] * $cos(a) - vecs[v].xi[q] * $sin(a);
            si = si + vecs[v].xr[q] * $sin(a) + vecs[v].xi[q] * $cos(a);
          end
          vecs[v].er[m] = sr / 8.0;
          vecs[v].ei[m] = si / 8.0;
        end
      end
    end
    fork
      forever begin
        @(posedge clk);
        #1;
        out_ready = bp ? ($urandom_range(0, 0) == 0 && (($time / 10) % 3 == 0)) : 1'b1;
      end
      begin
        bit stall;
        logic [7:0] pr, pi;
        logic pl;
        exp_t e;
        stall = 0;
        pr = 0;
        pi = 0;
        pl = 0;
        forever begin
          @(negedge clk);
          if (!rst && stall) begin
            check("stall_real_stable", int'(out_real), int'(pr));
            check("stall_image_stable", int'(out_image), int'(pi));
            check("stall_last_stable", int'(out_last), int'(pl));
          end
          if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_output: got real %0d with empty queue", $signed(out_real));
            end else begin
              e = sb.pop_front();
              checkr("out_real", int'($signed(out_real)), e.re, e.tol);
              checkr("out_image", int'($signed(out_image)), e.im, e.tol);
              check("out_last", int'(out_last), int'(e.last));
            end
          end
          stall = !rst && out_valid && !out_ready;
          pr = out_real;
          pi = out_image;
          pl = out_last;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_out_last", int'(out_last), 0);
    check("reset_out_real", int'(out_real), 0);
    check("reset_out_image", int'(out_image), 0);

    for (int v = 0; v < 6; v++) begin
      send(v, 1, 0);
      check("in_ready_after_frame", int'(in_ready), 0);
      check("busy_after_frame", int'(busy), 1);
      lat = 0;
      while (!out_valid && lat < 40) begin
        @(posedge clk);
        lat++;
        #1;
      end
      check("latency_edges", lat, 12);
      wait_empty();
    end

    bp = 1;
    send(2, 1, 1);
    wait_last();
    in_valid = 0;
    @(negedge clk);
    check("bp_in_ready_after_last", int'(in_ready), 1);
    check("bp_queue_empty", sb.size(), 0);
    bp = 0;
    @(posedge clk);
    #1;

    send(2, 0, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_busy", int'(busy), 0);
    send(0, 1, 0);
    wait_empty();

    send(0, 1, 0);
    in_valid = 1;
    in_real = 8'd64;
    in_image = 8'd0;
    wait_last();
    @(negedge clk);
    check("b2b_in_ready_one_cycle", int'(in_ready), 1);
    send(1, 1, 0);
    wait_empty();

    repeat (3) @(posedge clk);
    check("final_queue_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
